// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: parameter legality and stage-count helpers for the digit-pipelined adder
package pipelined_addsub_pkg;
  function automatic bit legal(int width, int digit);
    return digit >= 1 && width >= digit && width % digit == 0;
  endfunction
  function automatic int stages(int width, int digit);
    return width / digit;
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result bundle of the pipelined adder
interface pipelined_addsub_if #(parameter int WIDTH = 16);
  logic en, in_valid, sub, c, carry, ovf, out_valid;
  logic [WIDTH-1:0] a, b, s;
  modport master(output en, in_valid, sub, a, b, c, input s, carry, ovf, out_valid);
  modport slave(input en, in_valid, sub, a, b, c, output s, carry, ovf, out_valid);
endinterface

// File: rtl/addsub_digit_stage.sv
// addsub_digit_stage: resolves digit K and forwards the partially summed operands one stage
module addsub_digit_stage #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter int K = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cy_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             cy_o
);
  localparam int LO = K * DIGIT;
  logic [DIGIT:0] dsum;
  logic [WIDTH-1:0] x_d, y_d, x_q, y_q;
  logic valid_q, cy_q;
  assign dsum = {1'b0, x_i[LO +: DIGIT]} + {1'b0, y_i[LO +: DIGIT]} + {{DIGIT{1'b0}}, cy_i};
  // x carries finished sum digits below, raw A digits above; y keeps only the undone B' digits
  always_comb begin
    x_d = x_i;
    x_d[LO +: DIGIT] = dsum[DIGIT-1:0];
    y_d = y_i;
    y_d[LO +: DIGIT] = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      cy_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        x_q <= x_d;
        y_q <= y_d;
        cy_q <= dsum[DIGIT];
      end
    end
  end
  assign valid_o = valid_q;
  assign x_o = x_q;
  assign y_o = y_q;
  assign cy_o = cy_q;
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: two's-complement add/subtract resolving one DIGIT-bit slice per pipeline stage
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = stages(WIDTH, DIGIT);
  localparam int LO = WIDTH - DIGIT;
  if (!legal(WIDTH, DIGIT)) begin : g_bad
    $error("pipelined_addsub: WIDTH must be a positive multiple of DIGIT");
  end
  logic v_p [STAGES];
  logic c_p [STAGES];
  logic [WIDTH-1:0] x_p [STAGES];
  logic [WIDTH-1:0] y_p [STAGES];
  logic [WIDTH:0] sum_d, cin_d;
  logic [WIDTH-1:0] s_q;
  logic carry_q, ovf_q, out_valid_q, ovf_d;
  assign v_p[0] = bus.in_valid;
  assign x_p[0] = bus.a;
  assign y_p[0] = bus.sub ? ~bus.b : bus.b;
  assign c_p[0] = bus.c ^ bus.sub;
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
    addsub_digit_stage #(.WIDTH(WIDTH), .DIGIT(DIGIT), .K(k)) u_stage (
      .clk(clk), .rst(rst), .en_i(bus.en),
      .valid_i(v_p[k]), .x_i(x_p[k]), .y_i(y_p[k]), .cy_i(c_p[k]),
      .valid_o(v_p[k+1]), .x_o(x_p[k+1]), .y_o(y_p[k+1]), .cy_o(c_p[k+1])
    );
  end
  // lower digits of y are already zero, so a full-width add only resolves the top digit
  assign cin_d = {{WIDTH{1'b0}}, c_p[STAGES-1]} << LO;
  assign sum_d = {1'b0, x_p[STAGES-1]} + {1'b0, y_p[STAGES-1]} + cin_d;
  assign ovf_d = x_p[STAGES-1][WIDTH-1] ^ y_p[STAGES-1][WIDTH-1] ^ sum_d[WIDTH-1] ^ sum_d[WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.en) begin
      out_valid_q <= v_p[STAGES-1];
      if (v_p[STAGES-1]) begin
        s_q <= sum_d[WIDTH-1:0];
        carry_q <= sum_d[WIDTH];
        ovf_q <= ovf_d;
      end
    end
  end
  assign bus.s = s_q;
  assign bus.carry = carry_q;
  assign bus.ovf = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: four parameterisations driven in lockstep against an arithmetic/latency model
module tb_pipelined_addsub;
  logic clk, rst, en, in_valid, sub, c;
  logic [15:0] a, b;
  int n_cmp = 0, n_bad = 0;
  int W [4] = '{16, 3, 8, 12};
  int S [4] = '{4, 3, 1, 4};
  typedef struct { int inst; int rem; logic [17:0] r; } op_t;
  op_t q[$];
  logic [15:0] es [4];
  logic ec [4], eo [4], ev [4];
  logic [15:0] os [4];
  logic oc [4], oo [4], ov [4];

  pipelined_addsub_if #(.WIDTH(16)) b16 ();
  pipelined_addsub_if #(.WIDTH(3))  b3 ();
  pipelined_addsub_if #(.WIDTH(8))  b8 ();
  pipelined_addsub_if #(.WIDTH(12)) b12 ();
  assign {b16.en, b16.in_valid, b16.sub, b16.c, b16.a, b16.b} = {en, in_valid, sub, c, a, b};
  assign {b3.en, b3.in_valid, b3.sub, b3.c, b3.a, b3.b} = {en, in_valid, sub, c, a[2:0], b[2:0]};
  assign {b8.en, b8.in_valid, b8.sub, b8.c, b8.a, b8.b} = {en, in_valid, sub, c, a[7:0], b[7:0]};
  assign {b12.en, b12.in_valid, b12.sub, b12.c, b12.a, b12.b} = {en, in_valid, sub, c, a[11:0], b[11:0]};
  pipelined_addsub #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  pipelined_addsub #(.WIDTH(3),  .DIGIT(1)) u3  (.clk(clk), .rst(rst), .bus(b3.slave));
  pipelined_addsub #(.WIDTH(8),  .DIGIT(8)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  pipelined_addsub #(.WIDTH(12), .DIGIT(3)) u12 (.clk(clk), .rst(rst), .bus(b12.slave));
  always_comb begin
    os[0] = b16.s; os[1] = 16'(b3.s); os[2] = 16'(b8.s); os[3] = 16'(b12.s);
    oc[0] = b16.carry; oc[1] = b3.carry; oc[2] = b8.carry; oc[3] = b12.carry;
    oo[0] = b16.ovf; oo[1] = b3.ovf; oo[2] = b8.ovf; oo[3] = b12.ovf;
    ov[0] = b16.out_valid; ov[1] = b3.out_valid; ov[2] = b8.out_valid; ov[3] = b12.out_valid;
  end

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // result as {ovf, carry, s}, computed with integer arithmetic and sign comparison
  function automatic logic [17:0] ref_op(int w, logic sb, logic [15:0] aa, logic [15:0] bb, logic cc);
    int m, av, bv, full, s;
    logic cy, ovf;
    m = (1 << w) - 1;
    av = int'(aa) & m;
    bv = (sb ? ~int'(bb) : int'(bb)) & m;
    full = av + bv + int'(cc ^ sb);
    s = full & m;
    cy = ((full >> w) & 1) == 1;
    ovf = (((av >> (w-1)) & 1) == ((bv >> (w-1)) & 1)) && (((s >> (w-1)) & 1) != ((av >> (w-1)) & 1));
    return {ovf, cy, 16'(s)};
  endfunction

  task automatic model_edge();
    if (rst) begin
      q.delete();
      for (int i = 0; i < 4; i++) begin es[i] = 0; ec[i] = 0; eo[i] = 0; ev[i] = 0; end
    end else if (en) begin
      if (in_valid)
        for (int i = 0; i < 4; i++) q.push_back(op_t'{i, S[i], ref_op(W[i], sub, a, b, c)});
      for (int i = 0; i < 4; i++) ev[i] = 0;
      for (int j = 0; j < q.size(); j++) q[j].rem = q[j].rem - 1;
      for (int j = q.size() - 1; j >= 0; j--)
        if (q[j].rem == 0) begin
          ev[q[j].inst] = 1;
          {eo[q[j].inst], ec[q[j].inst], es[q[j].inst]} = q[j].r;
          q.delete(j);
        end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic v, input logic sb,
                     input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    rst = r; en = e; in_valid = v; sub = sb; a = aa; b = bb; c = cc;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid_w%0d", W[i]), 32'(ov[i]), 32'(ev[i]));
      chk($sformatf("s_w%0d", W[i]), 32'(os[i]), 32'(es[i]));
      chk($sformatf("carry_w%0d", W[i]), 32'(oc[i]), 32'(ec[i]));
      chk($sformatf("ovf_w%0d", W[i]), 32'(oo[i]), 32'(eo[i]));
    end
  endtask

  task automatic idle();
    cyc(0, 1, 0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  logic [15:0] bta [3] = '{16'hFFFF, 16'h0005, 16'h7FFF};
  logic [15:0] btb [3] = '{16'h0000, 16'h0007, 16'h0001};
  logic        btc [3] = '{1, 0, 0};
  logic        bts [3] = '{0, 1, 0};
  logic [17:0] btr [3] = '{{2'b01, 16'h0000}, {2'b00, 16'hFFFE}, {2'b10, 16'h8000}};
  logic        stv [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
  logic [15:0] sts [10] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                            16'h2345, 16'h2345, 16'h4000, 16'h4000};
  logic [15:0] w3s [3] = '{16'd2, 16'd3, 16'd5};
  int accepted = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1'($urandom), 1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      chk("rst_s", 32'(os[0]), 0);
      chk("rst_carry", 32'(oc[0]), 0);
      chk("rst_ovf", 32'(oo[0]), 0);
      chk("rst_valid", 32'(ov[0]), 0);
    end
    for (int k = 0; k < 3; k++) begin idle(); chk("post_rst_valid", 32'(ov[0]), 0); end
    cyc(0, 1, 1, 0, 16'h00FF, 16'h0001, 0);
    chk("single_lat0", 32'(ov[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("single_valid_%0d", k), 32'(ov[0]), k == 3 ? 1 : 0);
      if (k >= 3) chk("single_s", 32'(os[0]), 32'h0100);
    end
    chk("single_carry", 32'(oc[0]), 0);
    chk("single_ovf", 32'(oo[0]), 0);
    for (int j = 0; j < 6; j++) begin
      if (j < 3) cyc(0, 1, 1, bts[j], bta[j], btb[j], btc[j]);
      else begin
        idle();
        chk($sformatf("b2b_valid_%0d", j), 32'(ov[0]), 1);
        chk($sformatf("b2b_res_%0d", j), {14'b0, oo[0], oc[0], os[0]}, 32'(btr[j-3]));
      end
    end
    idle();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) cyc(0, 1, 1, 0, 16'h1234, 16'h1111, 0);
      else if (k == 2) cyc(0, 1, 1, 1, 16'h5000, 16'h1000, 0);
      else if (k >= 3 && k <= 5) cyc(0, 0, 1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      else idle();
      chk($sformatf("stall_valid_%0d", k), 32'(ov[0]), 32'(stv[k]));
      chk($sformatf("stall_s_%0d", k), 32'(os[0]), 32'(sts[k]));
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 2) cyc(0, 1, 1, 0, 16'(16'h0100 * (k + 1)), 16'h0001, 0);
      else if (k == 2) cyc(1, 1, 1, 0, 16'h0AAA, 16'h0001, 0);
      else if (k == 3) cyc(0, 1, 1, 0, 16'h0042, 16'h0001, 0);
      else idle();
      chk($sformatf("rstmid_valid_%0d", k), 32'(ov[0]), k == 6 ? 1 : 0);
      if (k == 5) chk("rstmid_s_cleared", 32'(os[0]), 0);
      if (k == 6) chk("rstmid_fresh_s", 32'(os[0]), 32'h0043);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 3) cyc(0, 1, 1, 0, 16'(k), 16'(k == 0 ? 2 : k == 1 ? 1 : 3), k == 1);
      else idle();
      if (k < 3) chk($sformatf("w8_s_%0d", k), 32'(os[2]), 32'(w3s[k]));
      chk($sformatf("w8_valid_%0d", k), 32'(ov[2]), k < 3 ? 1 : 0);
      if (k >= 2) chk($sformatf("w3_s_%0d", k), 32'(os[1]), 32'(w3s[k-2]));
      if (k >= 2) chk($sformatf("w3_valid_%0d", k), 32'(ov[1]), 1);
    end
    for (int n = 0; n < 3000 && accepted < 1000; n++) begin
      logic r, e, v;
      r = $urandom_range(99) == 0;
      e = $urandom_range(99) < 85;
      v = $urandom_range(99) < 90;
      if (!r && e && v) accepted++;
      cyc(r, e, v, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    chk("random_ops_done", 32'(accepted >= 1000), 1);
    for (int k = 0; k < 6; k++) idle();
    chk("drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
